// File: rtl/eai_pkg.sv
// Shared EAI field widths, request record and request-channel state encoding
// used by the host-model top and its ICB RAM.
package eai_pkg;

  localparam int DATA_W = 32;
  localparam int ITAG_W = 2;
  localparam int BYTE_LANES = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [ITAG_W-1:0] itag;
  } eai_req_t;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_PEND = 1'b1
  } req_state_t;

  // Instruction tags wrap naturally at 2**ITAG_W.
  function automatic logic [ITAG_W-1:0] itag_inc(input logic [ITAG_W-1:0] tag);
    return tag + ITAG_W'(1);
  endfunction

endpackage

// File: rtl/eai_icb_ram.sv
// ICB slave: one outstanding command, word-addressed RAM split into byte lanes
// so that masked writes map onto plain per-lane block RAMs.
module eai_icb_ram
  import eai_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_W-1:0]     cmd_addr,
  input  logic                  cmd_read,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [BYTE_LANES-1:0] cmd_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic              cmd_fire;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic [MEM_AW-1:0] word_idx;
  logic              addr_unused;

  // A new command may be taken once the previous response is gone or leaving.
  assign cmd_ready = ~rsp_valid_reg | rsp_ready;
  assign cmd_fire  = cmd_valid & cmd_ready;

  assign word_idx    = cmd_addr[MEM_AW+1:2];
  assign in_range    = (cmd_addr[DATA_W-1:MEM_AW+2] == '0);
  assign wr_en       = cmd_fire & ~cmd_read & in_range;
  assign rd_en       = cmd_read & in_range;
  assign addr_unused = ^cmd_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else if (cmd_fire) begin
      rsp_valid_reg <= 1'b1;
      rsp_err_reg   <= ~in_range;
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge clk) begin
      if (wr_en && cmd_wmask[gi]) begin
        mem[word_idx] <= cmd_wdata[gi*8 +: 8];
      end
    end

    // Writes and out-of-range reads answer with zero data.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_byte_reg <= '0;
      end else if (cmd_fire) begin
        rd_byte_reg <= rd_en ? mem[word_idx] : 8'h00;
      end
    end

    assign rsp_rdata[gi*8 +: 8] = rd_byte_reg;
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: rtl/eai_host_model.sv
// MCU stand-in driving the coprocessor EAI: turns an instruction strobe into a
// tagged request, tracks the outstanding response and serves ICB memory traffic.
module eai_host_model
  import eai_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_instr,
  input  logic [DATA_W-1:0]     instr,
  input  logic [DATA_W-1:0]     rs1_data,
  input  logic [DATA_W-1:0]     rs2_data,
  output logic                  eai_req_valid,
  input  logic                  eai_req_ready,
  output logic [DATA_W-1:0]     eai_req_instr,
  output logic [DATA_W-1:0]     eai_req_rs1,
  output logic [DATA_W-1:0]     eai_req_rs2,
  output logic [ITAG_W-1:0]     eai_req_itag,
  input  logic                  eai_rsp_valid,
  output logic                  eai_rsp_ready,
  input  logic [DATA_W-1:0]     eai_rsp_wdat,
  input  logic [ITAG_W-1:0]     eai_rsp_itag,
  input  logic                  eai_rsp_err,
  input  logic                  eai_icb_cmd_valid,
  output logic                  eai_icb_cmd_ready,
  input  logic [DATA_W-1:0]     eai_icb_cmd_addr,
  input  logic                  eai_icb_cmd_read,
  input  logic [DATA_W-1:0]     eai_icb_cmd_wdata,
  input  logic [BYTE_LANES-1:0] eai_icb_cmd_wmask,
  output logic                  eai_icb_rsp_valid,
  input  logic                  eai_icb_rsp_ready,
  output logic [DATA_W-1:0]     eai_icb_rsp_rdata,
  output logic                  eai_icb_rsp_err,
  input  logic                  eai_mem_holdup,
  output logic                  busy,
  output logic                  itag_err
);

  req_state_t        state_reg, state_next;
  eai_req_t          req_reg, req_next;
  logic [ITAG_W-1:0] itag_cnt_reg, itag_cnt_next;
  logic [ITAG_W-1:0] last_itag_reg, last_itag_next;
  logic              busy_reg, busy_next;
  logic              itag_err_reg, itag_err_next;
  logic              rsp_ready_reg;

  logic              req_fire;
  logic              rsp_fire;
  logic [ITAG_W-1:0] expect_itag;
  logic              rsp_unused;

  assign req_fire = (state_reg == REQ_PEND) & eai_req_ready;
  assign rsp_fire = eai_rsp_valid & rsp_ready_reg;
  // Writeback data and error are only observed by the coprocessor's checker.
  assign rsp_unused = ^{eai_rsp_wdat, eai_rsp_err};

  // A response racing the acceptance is matched against the tag going out now.
  assign expect_itag = req_fire ? req_reg.itag : last_itag_reg;

  always_comb begin
    state_next     = state_reg;
    req_next       = req_reg;
    itag_cnt_next  = itag_cnt_reg;
    last_itag_next = last_itag_reg;
    busy_next      = busy_reg;
    itag_err_next  = itag_err_reg;

    unique case (state_reg)
      REQ_IDLE: begin
        if (send_instr && !eai_mem_holdup) begin
          req_next.instr = instr;
          req_next.rs1   = rs1_data;
          req_next.rs2   = rs2_data;
          req_next.itag  = itag_cnt_reg;
          state_next     = REQ_PEND;
        end
      end
      REQ_PEND: begin
        if (eai_req_ready) begin
          state_next     = REQ_IDLE;
          itag_cnt_next  = itag_inc(itag_cnt_reg);
          last_itag_next = req_reg.itag;
          busy_next      = 1'b1;
        end
      end
      default: state_next = REQ_IDLE;
    endcase

    // Response after acceptance so that a same-cycle response leaves busy low.
    if (rsp_fire) begin
      busy_next = 1'b0;
      if (eai_rsp_itag != expect_itag) begin
        itag_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= REQ_IDLE;
      req_reg       <= '0;
      itag_cnt_reg  <= '0;
      last_itag_reg <= '0;
      busy_reg      <= 1'b0;
      itag_err_reg  <= 1'b0;
      rsp_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= req_next;
      itag_cnt_reg  <= itag_cnt_next;
      last_itag_reg <= last_itag_next;
      busy_reg      <= busy_next;
      itag_err_reg  <= itag_err_next;
      rsp_ready_reg <= 1'b1;
    end
  end

  assign eai_req_valid = (state_reg == REQ_PEND);
  assign eai_req_instr = req_reg.instr;
  assign eai_req_rs1   = req_reg.rs1;
  assign eai_req_rs2   = req_reg.rs2;
  assign eai_req_itag  = req_reg.itag;
  assign eai_rsp_ready = rsp_ready_reg;
  assign busy          = busy_reg;
  assign itag_err      = itag_err_reg;

  eai_icb_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_AW    (MEM_AW)
  ) u_icb_ram (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (eai_icb_cmd_valid),
    .cmd_ready (eai_icb_cmd_ready),
    .cmd_addr  (eai_icb_cmd_addr),
    .cmd_read  (eai_icb_cmd_read),
    .cmd_wdata (eai_icb_cmd_wdata),
    .cmd_wmask (eai_icb_cmd_wmask),
    .rsp_valid (eai_icb_rsp_valid),
    .rsp_ready (eai_icb_rsp_ready),
    .rsp_rdata (eai_icb_rsp_rdata),
    .rsp_err   (eai_icb_rsp_err)
  );

endmodule

// File: tb/tb_eai_host_model.sv
// Self-checking bench for eai_host_model: directed EAI/ICB sequences, an ICB
// vector table and a randomized run against a behavioural reference model.
module tb_eai_host_model;

  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = 10;
  localparam int REF_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_instr;
  logic [31:0] instr, rs1_data, rs2_data;
  logic        eai_req_valid, eai_req_ready;
  logic [31:0] eai_req_instr, eai_req_rs1, eai_req_rs2;
  logic [1:0]  eai_req_itag;
  logic        eai_rsp_valid, eai_rsp_ready;
  logic [31:0] eai_rsp_wdat;
  logic [1:0]  eai_rsp_itag;
  logic        eai_rsp_err;
  logic        eai_icb_cmd_valid, eai_icb_cmd_ready;
  logic [31:0] eai_icb_cmd_addr;
  logic        eai_icb_cmd_read;
  logic [31:0] eai_icb_cmd_wdata;
  logic [3:0]  eai_icb_cmd_wmask;
  logic        eai_icb_rsp_valid, eai_icb_rsp_ready;
  logic [31:0] eai_icb_rsp_rdata;
  logic        eai_icb_rsp_err;
  logic        eai_mem_holdup;
  logic        busy, itag_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  eai_host_model #(.MEM_DEPTH(MEM_DEPTH), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .send_instr(send_instr), .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .eai_req_valid(eai_req_valid), .eai_req_ready(eai_req_ready),
    .eai_req_instr(eai_req_instr), .eai_req_rs1(eai_req_rs1), .eai_req_rs2(eai_req_rs2),
    .eai_req_itag(eai_req_itag),
    .eai_rsp_valid(eai_rsp_valid), .eai_rsp_ready(eai_rsp_ready), .eai_rsp_wdat(eai_rsp_wdat),
    .eai_rsp_itag(eai_rsp_itag), .eai_rsp_err(eai_rsp_err),
    .eai_icb_cmd_valid(eai_icb_cmd_valid), .eai_icb_cmd_ready(eai_icb_cmd_ready),
    .eai_icb_cmd_addr(eai_icb_cmd_addr), .eai_icb_cmd_read(eai_icb_cmd_read),
    .eai_icb_cmd_wdata(eai_icb_cmd_wdata), .eai_icb_cmd_wmask(eai_icb_cmd_wmask),
    .eai_icb_rsp_valid(eai_icb_rsp_valid), .eai_icb_rsp_ready(eai_icb_rsp_ready),
    .eai_icb_rsp_rdata(eai_icb_rsp_rdata), .eai_icb_rsp_err(eai_icb_rsp_err),
    .eai_mem_holdup(eai_mem_holdup), .busy(busy), .itag_err(itag_err)
  );

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } icb_vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  itag;
  } ref_req_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    send_instr = 0; instr = 0; rs1_data = 0; rs2_data = 0;
    eai_req_ready = 0; eai_rsp_valid = 0; eai_rsp_wdat = 0; eai_rsp_itag = 0; eai_rsp_err = 0;
    eai_icb_cmd_valid = 0; eai_icb_cmd_addr = 0; eai_icb_cmd_read = 0;
    eai_icb_cmd_wdata = 0; eai_icb_cmd_wmask = 0; eai_icb_rsp_ready = 0; eai_mem_holdup = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic issue(input logic [31:0] i_w, input logic [31:0] a, input logic [31:0] b);
    send_instr = 1; instr = i_w; rs1_data = a; rs2_data = b;
    cyc();
    send_instr = 0;
    $display("issue instr=0x%08h itag=%0d", i_w, eai_req_itag);
  endtask

  // Reference model state for the randomized phase.
  bit          m_pend, m_busy, m_err, m_icb_v, m_icb_err;
  logic [1:0]  m_tag, m_last;
  ref_req_t    m_req;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [REF_WORDS];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    icb_vec_t vecs[12];
    logic [31:0] exp_w;
    bit          in_rng;
    int          widx;

    vecs[0]  = '{0, 32'h0000_0008, 32'h0000_0000, 4'hF, 32'h0, 0};
    vecs[1]  = '{0, 32'h0000_0008, 32'h1122_3344, 4'h5, 32'h0, 0};
    vecs[2]  = '{1, 32'h0000_0008, 32'h0,         4'h0, 32'h0022_0044, 0};
    vecs[3]  = '{1, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1};
    vecs[4]  = '{0, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0, 0};
    vecs[5]  = '{0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1};
    vecs[6]  = '{1, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5, 0};
    vecs[7]  = '{0, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 0};
    vecs[8]  = '{1, 32'h0000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 0};
    vecs[9]  = '{0, 32'h0000_0008, 32'hAABB_CCDD, 4'hA, 32'h0, 0};
    vecs[10] = '{1, 32'h0000_0008, 32'h0,         4'h0, 32'hAA22_CC44, 0};
    vecs[11] = '{1, 32'h8000_0008, 32'h0,         4'h0, 32'h0, 1};

    // ---- reset values
    do_reset();
    rst = 1;
    chk("rst_req_valid", 32'(eai_req_valid), 0);
    chk("rst_req_instr", eai_req_instr, 0);
    chk("rst_req_itag", 32'(eai_req_itag), 0);
    chk("rst_rsp_ready", 32'(eai_rsp_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_itag_err", 32'(itag_err), 0);
    chk("rst_icb_rsp_valid", 32'(eai_icb_rsp_valid), 0);
    chk("rst_icb_rdata", eai_icb_rsp_rdata, 0);
    chk("rst_icb_err", 32'(eai_icb_rsp_err), 0);
    rst = 0;

    // ---- request held under back-pressure, then accepted
    issue(32'h0000_200B, 32'h10, 32'h20);
    chk("rsp_ready_after_rst", 32'(eai_rsp_ready), 1);
    for (int c = 1; c <= 4; c++) begin
      chk("hold_req_valid", 32'(eai_req_valid), 1);
      chk("hold_req_instr", eai_req_instr, 32'h0000_200B);
      chk("hold_req_rs1", eai_req_rs1, 32'h10);
      chk("hold_req_rs2", eai_req_rs2, 32'h20);
      chk("hold_req_itag", 32'(eai_req_itag), 0);
      chk("hold_busy", 32'(busy), 0);
      if (c == 4) eai_req_ready = 1;
      cyc();
    end
    eai_req_ready = 0;
    chk("acc_req_valid", 32'(eai_req_valid), 0);
    chk("acc_busy", 32'(busy), 1);

    // ---- matching response, then mismatched tag
    eai_rsp_valid = 1; eai_rsp_itag = 0; eai_rsp_wdat = 32'hDEAD_BEEF;
    #1 chk("rsp_ready", 32'(eai_rsp_ready), 1);
    cyc();
    eai_rsp_valid = 0;
    chk("rsp_busy_clear", 32'(busy), 0);
    chk("rsp_itag_ok", 32'(itag_err), 0);
    issue(32'h0000_300B, 32'h1, 32'h2);
    chk("second_itag", 32'(eai_req_itag), 1);
    eai_req_ready = 1;
    cyc();
    eai_req_ready = 0;
    eai_rsp_valid = 1; eai_rsp_itag = 3;
    cyc();
    eai_rsp_valid = 0;
    chk("bad_tag_err", 32'(itag_err), 1);
    chk("bad_tag_busy", 32'(busy), 0);
    cyc(); cyc();
    chk("itag_err_sticky", 32'(itag_err), 1);

    // ---- five back-to-back instructions, tags wrap mod 4
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue($urandom, $urandom, $urandom);
      chk("b2b_itag", 32'(eai_req_itag), 32'(i % 4));
      eai_req_ready = 1;
      cyc();
      eai_req_ready = 0;
      eai_rsp_valid = 1; eai_rsp_itag = 2'(i % 4);
      cyc();
      eai_rsp_valid = 0;
      chk("b2b_busy", 32'(busy), 0);
    end
    chk("b2b_itag_err", 32'(itag_err), 0);

    // ---- same-cycle accept and response: response wins
    issue(32'h0000_400B, 32'h3, 32'h4);
    eai_req_ready = 1; eai_rsp_valid = 1; eai_rsp_itag = 1;
    cyc();
    eai_req_ready = 0; eai_rsp_valid = 0;
    chk("race_busy", 32'(busy), 0);
    chk("race_req_valid", 32'(eai_req_valid), 0);

    // ---- ICB vector table
    eai_icb_rsp_ready = 1;
    foreach (vecs[i]) begin
      eai_icb_cmd_valid = 1; eai_icb_cmd_read = vecs[i].rd; eai_icb_cmd_addr = vecs[i].addr;
      eai_icb_cmd_wdata = vecs[i].wdata; eai_icb_cmd_wmask = vecs[i].wmask;
      #1 chk("icb_cmd_ready", 32'(eai_icb_cmd_ready), 1);
      cyc();
      eai_icb_cmd_valid = 0;
      $display("icb %s addr=0x%08h rdata=0x%08h err=%0d", vecs[i].rd ? "rd" : "wr",
               vecs[i].addr, eai_icb_rsp_rdata, eai_icb_rsp_err);
      chk("icb_rsp_valid", 32'(eai_icb_rsp_valid), 1);
      chk("icb_rdata", eai_icb_rsp_rdata, vecs[i].exp_rdata);
      chk("icb_err", 32'(eai_icb_rsp_err), 32'(vecs[i].exp_err));
      cyc();
      chk("icb_rsp_drained", 32'(eai_icb_rsp_valid), 0);
    end

    // ---- ICB response back-pressure
    eai_icb_rsp_ready = 0;
    eai_icb_cmd_valid = 1; eai_icb_cmd_read = 1; eai_icb_cmd_addr = 32'h8;
    cyc();
    eai_icb_cmd_addr = 32'h0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_cmd_ready", 32'(eai_icb_cmd_ready), 0);
      chk("bp_rsp_valid", 32'(eai_icb_rsp_valid), 1);
      chk("bp_rdata", eai_icb_rsp_rdata, 32'hAA22_CC44);
      cyc();
    end
    eai_icb_rsp_ready = 1;
    #1 chk("bp_release_ready", 32'(eai_icb_cmd_ready), 1);
    cyc();
    eai_icb_cmd_valid = 0;
    chk("bp_next_rdata", eai_icb_rsp_rdata, 32'hA5A5_A5A5);
    cyc();
    chk("bp_drained", 32'(eai_icb_rsp_valid), 0);

    // ---- holdup drops the strobe; reset discards outstanding work
    do_reset();
    cyc();
    eai_mem_holdup = 1;
    issue(32'h0000_500B, 32'h5, 32'h6);
    eai_mem_holdup = 0;
    chk("holdup_no_req", 32'(eai_req_valid), 0);
    cyc();
    chk("holdup_still_idle", 32'(eai_req_valid), 0);
    issue(32'h0000_600B, 32'h7, 32'h8);
    eai_req_ready = 1;
    cyc();
    eai_req_ready = 0;
    chk("pre_rst_busy", 32'(busy), 1);
    issue(32'h0000_700B, 32'h9, 32'hA);
    eai_icb_cmd_valid = 1; eai_icb_cmd_read = 1; eai_icb_cmd_addr = 32'h0; eai_icb_rsp_ready = 0;
    cyc();
    eai_icb_cmd_valid = 0;
    chk("pre_rst_icb_valid", 32'(eai_icb_rsp_valid), 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_req_valid", 32'(eai_req_valid), 0);
    chk("mid_rst_icb_valid", 32'(eai_icb_rsp_valid), 0);

    // ---- randomized run against the reference model
    do_reset();
    eai_icb_rsp_ready = 1;
    for (int w = 0; w < REF_WORDS; w++) begin
      eai_icb_cmd_valid = 1; eai_icb_cmd_read = 0; eai_icb_cmd_addr = 32'(w * 4);
      eai_icb_cmd_wdata = 0; eai_icb_cmd_wmask = 4'hF;
      cyc();
      ref_mem[w] = 0;
    end
    eai_icb_cmd_valid = 0;
    cyc();
    m_pend = 0; m_busy = 0; m_err = 0; m_icb_v = 0; m_icb_err = 0;
    m_tag = 0; m_last = 0; m_rdata = 0; m_req = '{0, 0, 0, 0};

    for (int t = 0; t < 400; t++) begin
      bit accept, rsp, fire;
      logic [1:0] exp_tag;

      send_instr = ($urandom_range(3) == 0);
      instr = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      eai_mem_holdup = ($urandom_range(7) == 0);
      eai_req_ready = 1'($urandom_range(1));
      accept = m_pend && eai_req_ready;
      exp_tag = accept ? m_req.itag : m_last;
      eai_rsp_valid = ($urandom_range(2) == 0);
      eai_rsp_itag = ($urandom_range(7) == 0) ? 2'($urandom) : exp_tag;
      eai_rsp_wdat = $urandom; eai_rsp_err = 1'($urandom_range(1));

      eai_icb_cmd_valid = 1'($urandom_range(1));
      eai_icb_cmd_read = 1'($urandom_range(1));
      widx = $urandom_range(REF_WORDS - 1);
      if ($urandom_range(5) == 0)
        eai_icb_cmd_addr = (32'($urandom_range(1, 8)) << 12) | 32'(widx * 4);
      else
        eai_icb_cmd_addr = 32'(widx * 4) | 32'($urandom_range(3));
      eai_icb_cmd_wdata = $urandom; eai_icb_cmd_wmask = 4'($urandom);
      eai_icb_rsp_ready = 1'($urandom_range(1));

      #1 chk("rnd_cmd_ready", 32'(eai_icb_cmd_ready), 32'(!m_icb_v || eai_icb_rsp_ready));

      // EAI model
      rsp = eai_rsp_valid;
      if (rsp && eai_rsp_itag != exp_tag) m_err = 1;
      if (accept) begin
        m_pend = 0; m_last = m_req.itag; m_tag = 2'((m_tag + 1) % 4); m_busy = 1;
      end else if (send_instr && !m_pend && !eai_mem_holdup) begin
        m_pend = 1; m_req = '{instr, rs1_data, rs2_data, m_tag};
      end
      if (rsp) m_busy = 0;

      // ICB model
      fire = eai_icb_cmd_valid && (!m_icb_v || eai_icb_rsp_ready);
      if (fire) begin
        in_rng = (eai_icb_cmd_addr >> 12) == 0;
        m_icb_v = 1; m_icb_err = !in_rng; m_rdata = 0;
        if (in_rng && eai_icb_cmd_read) begin
          m_rdata = ref_mem[widx];
        end else if (in_rng) begin
          exp_w = ref_mem[widx];
          for (int b = 0; b < 4; b++)
            if (eai_icb_cmd_wmask[b]) exp_w[b*8 +: 8] = eai_icb_cmd_wdata[b*8 +: 8];
          ref_mem[widx] = exp_w;
        end
      end else if (eai_icb_rsp_ready) begin
        m_icb_v = 0;
      end

      cyc();
      $display("rnd %0d req_v=%0d itag=%0d busy=%0d icb_v=%0d rdata=0x%08h", t,
               eai_req_valid, eai_req_itag, busy, eai_icb_rsp_valid, eai_icb_rsp_rdata);
      chk("rnd_req_valid", 32'(eai_req_valid), 32'(m_pend));
      if (m_pend) begin
        chk("rnd_req_instr", eai_req_instr, m_req.instr);
        chk("rnd_req_rs1", eai_req_rs1, m_req.rs1);
        chk("rnd_req_rs2", eai_req_rs2, m_req.rs2);
        chk("rnd_req_itag", 32'(eai_req_itag), 32'(m_req.itag));
      end
      chk("rnd_busy", 32'(busy), 32'(m_busy));
      chk("rnd_itag_err", 32'(itag_err), 32'(m_err));
      chk("rnd_rsp_ready", 32'(eai_rsp_ready), 1);
      chk("rnd_icb_valid", 32'(eai_icb_rsp_valid), 32'(m_icb_v));
      if (m_icb_v) begin
        chk("rnd_icb_rdata", eai_icb_rsp_rdata, m_rdata);
        chk("rnd_icb_err", 32'(eai_icb_rsp_err), 32'(m_icb_err));
      end
    end

    clear_inputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eai_host_model.md
Name: eai_host_model

Overview:
- Cycle-accurate RISC-V MCU stand-in that drives the EAI (extension accelerator interface) of the hwpe coprocessor.
- Converts a one-cycle instruction strobe into an EAI request transaction and always accepts EAI responses.
- Serves the coprocessor's ICB memory-port requests from a local word-addressed RAM.
- Sits between the test sequencer and the accelerator top.

Parameters:
- MEM_DEPTH, 1024: ICB RAM depth in 32-bit words (power of two).
- MEM_AW, 10: log2(MEM_DEPTH).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- send_instr  in  1  one-cycle strobe: issue instr/rs1_data/rs2_data.
- instr  in  32  custom instruction word.
- rs1_data  in  32  rs1 operand.
- rs2_data  in  32  rs2 operand.
- eai_req_valid  out  1  request valid.
- eai_req_ready  in  1  coprocessor accepts request.
- eai_req_instr  out  32  latched instr.
- eai_req_rs1  out  32  latched rs1.
- eai_req_rs2  out  32  latched rs2.
- eai_req_itag  out  2  instruction tag.
- eai_rsp_valid  in  1  response valid.
- eai_rsp_ready  out  1  response accept.
- eai_rsp_wdat  in  32  rd writeback data.
- eai_rsp_itag  in  2  response tag.
- eai_rsp_err  in  1  response error.
- eai_icb_cmd_valid  in  1  memory command valid.
- eai_icb_cmd_ready  out  1  memory command accept.
- eai_icb_cmd_addr  in  32  byte address.
- eai_icb_cmd_read  in  1  1 = read, 0 = write.
- eai_icb_cmd_wdata  in  32  write data.
- eai_icb_cmd_wmask  in  4  byte enables.
- eai_icb_rsp_valid  out  1  memory response valid.
- eai_icb_rsp_ready  in  1  memory response accept.
- eai_icb_rsp_rdata  out  32  read data.
- eai_icb_rsp_err  out  1  out-of-range access.
- eai_mem_holdup  in  1  coprocessor requests the MCU stall new issue.
- busy  out  1  request issued and response not yet received.
- itag_err  out  1  sticky: response tag mismatched the outstanding tag.

Behaviour:
- Reset values: eai_req_valid=0, all req data=0, itag counter=0, eai_rsp_ready=0, busy=0, itag_err=0, eai_icb_rsp_valid=0, rdata=0, icb err=0. RAM contents are not reset.
- Outside reset, eai_rsp_ready is registered 1 from the first cycle after rst deasserts.
- Issue: send_instr sampled at posedge. If no request is pending (req_valid=0) and eai_mem_holdup=0:
  - latch instr/rs1/rs2 and the current itag;
  - set eai_req_valid=1 at that same edge (1-cycle latency).
- Otherwise the strobe is dropped. The sequencer only strobes when idle.
- Request handshake: eai_req_valid holds and its data is stable until a cycle with valid&ready. At that edge valid clears, itag increments mod 4, and busy sets.
- Response: on eai_rsp_valid&eai_rsp_ready, busy clears. If eai_rsp_itag differs from the last issued tag, itag_err sets (sticky until rst). eai_rsp_err and wdat are observed only; nothing is stored.
- A response in the same cycle as request acceptance: busy ends 0 (response wins).
- ICB memory, one outstanding command:
  - eai_icb_cmd_ready = ~eai_icb_rsp_valid | eai_icb_rsp_ready (combinational).
  - On cmd handshake, eai_icb_rsp_valid is set next cycle.
  - Word index = addr[MEM_AW+1:2].
  - Read: rdata = RAM[index].
  - Write: per-byte update with wmask; rdata = 0.
  - rsp_valid is held until eai_icb_rsp_ready.
- Out of range (addr[31:MEM_AW+2] nonzero): no RAM write; rdata=0; eai_icb_rsp_err=1.
- Reset mid-operation: pending request, busy, and outstanding ICB response are all discarded.

Decomposition:
- Shared package `eai_pkg`: EAI field widths (32-bit data, 2-bit itag) and a request struct {instr, rs1, rs2, itag}.
- One sub-module, `eai_icb_ram`: ICB slave with byte-mask RAM and error flag. The top holds the request/response logic.

Test Plan:
- Reset, then pulse send_instr with instr=0x0000_200B, rs1=0x10, rs2=0x20; hold req_ready=0 for 3 cycles, then 1 → req_valid high 4 cycles with stable data and itag=0; after the handshake busy=1 and the next itag is 1.
- Response with rsp_valid=1, itag=0, wdat=0xDEAD_BEEF → rsp_ready=1, busy clears, itag_err stays 0; repeating with itag=3 while itag 1 is outstanding → itag_err=1.
- Issue 5 instructions back to back, each answered → issued itags are 0,1,2,3,0.
- ICB write addr=0x8, wdata=0x1122_3344, mask=0b0101; read addr=0x8 → rdata=0x0022_0044 (preloaded 0) with err=0; a read at addr=0x1000 (MEM_DEPTH=1024) → err=1, rdata=0.
- Hold icb_rsp_ready=0 for 2 cycles → cmd_ready=0 and rsp_valid/rdata held; accept occurs on release.
- eai_mem_holdup=1 during a send_instr strobe → no request issued; assert rst while busy → busy=0 and req_valid=0 on the next cycle.
